// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and memory (slave).
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_stage.sv
// CPU memory-access stage: ALU ops pass through, loads/stores run a req/ack access with
// timeout and misalignment rejection, and all results land in the MEM/WB latch.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] alu_result,
  input  logic [15:0] store_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  input  logic [2:0]  wr_reg_in,
  output logic        stall,
  mem_stage_if.master mem,
  output logic [15:0] read_data,
  output logic [15:0] alu_out,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic [2:0]  wr_reg,
  output logic        valid_out,
  output logic        err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_req, r_we;
  logic [15:0] r_addr, r_wdata;
  logic        r_cap_m2r, r_cap_rw;
  logic [2:0]  r_cap_wr;
  logic [15:0] r_rdata, r_alu;
  logic        r_m2r, r_rw, r_vld, r_err;
  logic [2:0]  r_wr;

  logic w_mem_op, w_mis, w_issue, w_last;

  assign w_mem_op = valid_in & (MemRead | MemWrite);
  assign w_mis    = alu_result[0];
  assign w_issue  = w_mem_op & ~w_mis;
  assign w_last   = (r_cnt == TO_LAST);

  // Stall is released in the ack cycle or the final timeout cycle so upstream advances at that edge.
  always_comb begin
    stall = 1'b0;
    if (r_state == S_IDLE) stall = w_issue;
    else                   stall = ~mem.mem_ack & ~w_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cap_m2r <= 1'b0;
      r_cap_rw  <= 1'b0;
      r_cap_wr  <= '0;
      r_rdata   <= '0;
      r_alu     <= '0;
      r_m2r     <= 1'b0;
      r_rw      <= 1'b0;
      r_wr      <= '0;
      r_vld     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_req     <= 1'b1;
            r_we      <= MemWrite;
            r_addr    <= alu_result;
            r_wdata   <= store_data;
            r_cap_m2r <= MemToReg_in;
            r_cap_rw  <= RegWrite_in;
            r_cap_wr  <= wr_reg_in;
            r_cnt     <= '0;
            r_state   <= S_WAIT;
            r_vld     <= 1'b0;
            r_rw      <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
          end else begin
            // Only a misaligned memory op reaches here as a memory op.
            r_vld   <= valid_in;
            r_alu   <= alu_result;
            r_m2r   <= MemToReg_in;
            r_wr    <= wr_reg_in;
            r_rw    <= RegWrite_in & ~w_mem_op;
            r_err   <= w_mem_op;
            r_rdata <= '0;
          end
        end
        S_WAIT: begin
          if (mem.mem_ack || w_last) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
            r_vld   <= 1'b1;
            r_alu   <= r_addr;
            r_m2r   <= r_cap_m2r;
            r_wr    <= r_cap_wr;
            r_rw    <= mem.mem_ack & r_cap_rw;
            r_err   <= ~mem.mem_ack;
            r_rdata <= (mem.mem_ack && !r_we) ? mem.mem_rdata : 16'h0000;
          end else begin
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            r_vld   <= 1'b0;
            r_rw    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;

  assign read_data = r_rdata;
  assign alu_out   = r_alu;
  assign MemToReg  = r_m2r;
  assign RegWrite  = r_rw;
  assign wr_reg    = r_wr;
  assign valid_out = r_vld;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT = 4): ALU pass-through, load, misaligned store,
// timeout with late ack, back-to-back accesses and reset mid-access.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, MemRead, MemWrite, MemToReg_in, RegWrite_in;
  logic [15:0] alu_result, store_data;
  logic [2:0]  wr_reg_in;
  logic        stall, MemToReg, RegWrite, valid_out, err;
  logic [15:0] read_data, alu_out;
  logic [2:0]  wr_reg;
  int          n_chk = 0, n_pass = 0;
  int          req_hi;

  mem_stage_if mif ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .wr_reg_in(wr_reg_in),
    .stall(stall), .mem(mif), .read_data(read_data), .alu_out(alu_out),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .wr_reg(wr_reg),
    .valid_out(valid_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr_in();
    valid_in = 0; MemRead = 0; MemWrite = 0; MemToReg_in = 0; RegWrite_in = 0;
    alu_result = '0; store_data = '0; wr_reg_in = '0;
    mif.mem_ack = 0; mif.mem_rdata = '0;
  endtask

  task automatic nx();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                    input logic m2r, input logic rw, input logic [2:0] r);
    valid_in = 1; MemRead = rd; MemWrite = wr; alu_result = a; store_data = d;
    MemToReg_in = m2r; RegWrite_in = rw; wr_reg_in = r;
  endtask

  initial begin
    rst_n = 0; clr_in();
    nx(); @(negedge clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    nx(); rst_n = 1;

    // ALU pass-through
    op(0, 0, 16'h1234, 0, 0, 1, 3'd5);
    @(negedge clk); chk("alu_stall", stall, 0);
    nx(); clr_in();
    @(negedge clk);
    chk("alu_out", alu_out, 16'h1234);
    chk("alu_rw", RegWrite, 1);
    chk("alu_wr", wr_reg, 5);
    chk("alu_valid", valid_out, 1);
    chk("alu_stall2", stall, 0);

    // Load 0x0040, ack in cycle 3
    nx(); op(1, 0, 16'h0040, 0, 1, 1, 3'd3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ld_stall", stall, 1);
      chk("ld_req", mif.mem_req, (c > 0) ? 1 : 0);
      if (c > 0) begin
        chk("ld_addr", mif.mem_addr, 16'h0040);
        chk("ld_we", mif.mem_we, 0);
        chk("ld_bubble", valid_out, 0);
      end
      nx();
    end
    mif.mem_ack = 1; mif.mem_rdata = 16'hBEEF;
    @(negedge clk); chk("ld_stall_ack", stall, 0);
    nx(); clr_in();
    @(negedge clk);
    chk("ld_data", read_data, 16'hBEEF);
    chk("ld_valid", valid_out, 1);
    chk("ld_alu", alu_out, 16'h0040);
    chk("ld_rw", RegWrite, 1);
    chk("ld_wr", wr_reg, 3);
    chk("ld_m2r", MemToReg, 1);
    chk("ld_err", err, 0);
    chk("ld_req_drop", mif.mem_req, 0);

    // Misaligned store
    nx(); op(0, 1, 16'h0003, 16'hAAAA, 0, 1, 3'd2);
    @(negedge clk);
    chk("mis_stall", stall, 0);
    nx(); clr_in();
    @(negedge clk);
    chk("mis_req", mif.mem_req, 0);
    chk("mis_err", err, 1);
    chk("mis_rw", RegWrite, 0);
    chk("mis_valid", valid_out, 1);
    chk("mis_rdata", read_data, 0);

    // Timeout (TIMEOUT = 4), then a late ack in IDLE
    nx(); op(1, 0, 16'h0100, 0, 1, 1, 3'd2);
    req_hi = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("to_stall", stall, (c < 4) ? 1 : 0);
      if (mif.mem_req) req_hi++;
      nx();
    end
    chk("to_req_cycles", req_hi, 4);
    clr_in(); mif.mem_ack = 1; mif.mem_rdata = 16'h1111;
    @(negedge clk);
    chk("to_err", err, 1);
    chk("to_rw", RegWrite, 0);
    chk("to_valid", valid_out, 1);
    chk("to_rdata", read_data, 0);
    chk("to_req_off", mif.mem_req, 0);
    chk("late_stall", stall, 0);
    nx(); clr_in();
    @(negedge clk);
    chk("late_req", mif.mem_req, 0);
    chk("late_valid", valid_out, 0);
    chk("late_rdata", read_data, 0);
    chk("late_err", err, 0);

    // Back-to-back: store (k=1) then load (k=2)
    nx(); op(0, 1, 16'h0010, 16'h5A5A, 0, 0, 3'd1);
    nx(); mif.mem_ack = 1;
    @(negedge clk);
    chk("b2b_st_req", mif.mem_req, 1);
    chk("b2b_st_we", mif.mem_we, 1);
    chk("b2b_st_wdata", mif.mem_wdata, 16'h5A5A);
    chk("b2b_st_stall", stall, 0);
    nx(); clr_in(); op(1, 0, 16'h0020, 0, 1, 1, 3'd6);
    @(negedge clk);
    chk("b2b_gap_req", mif.mem_req, 0);
    chk("b2b_st_valid", valid_out, 1);
    chk("b2b_st_rdata", read_data, 0);
    chk("b2b_st_wr", wr_reg, 1);
    chk("b2b_ld_stall0", stall, 1);
    nx();
    @(negedge clk);
    chk("b2b_ld_req", mif.mem_req, 1);
    chk("b2b_ld_addr", mif.mem_addr, 16'h0020);
    chk("b2b_ld_we", mif.mem_we, 0);
    chk("b2b_bubble", valid_out, 0);
    nx(); mif.mem_ack = 1; mif.mem_rdata = 16'hC0DE;
    @(negedge clk);
    chk("b2b_ld_stall2", stall, 0);
    chk("b2b_ld_req2", mif.mem_req, 1);
    nx(); clr_in();
    @(negedge clk);
    chk("b2b_ld_valid", valid_out, 1);
    chk("b2b_ld_data", read_data, 16'hC0DE);
    chk("b2b_ld_wr", wr_reg, 6);
    chk("b2b_ld_req_off", mif.mem_req, 0);
    nx();
    @(negedge clk);
    chk("b2b_one_pulse", valid_out, 0);

    // Reset mid-WAIT
    nx(); op(1, 0, 16'h0080, 0, 0, 1, 3'd4);
    nx();
    @(negedge clk); chk("rw_req_pre", mif.mem_req, 1);
    #1 rst_n = 0;
    #1;
    chk("rw_req", mif.mem_req, 0);
    chk("rw_valid", valid_out, 0);
    chk("rw_err", err, 0);
    chk("rw_rw", RegWrite, 0);
    clr_in();
    nx(); rst_n = 1;
    op(0, 0, 16'h0BAD, 0, 0, 1, 3'd7);
    @(negedge clk); chk("rw_alu_stall", stall, 0);
    nx(); clr_in();
    @(negedge clk);
    chk("rw_alu_out", alu_out, 16'h0BAD);
    chk("rw_alu_valid", valid_out, 1);
    chk("rw_alu_wr", wr_reg, 7);
    chk("rw_alu_req", mif.mem_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
